// File: rtl/cpl_source_arbiter_pkg.sv
// Shared AXI-slave response-path types: completion type, arbiter state and
// the completion-length to R-beat conversion.
package axi_slave_package;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPL  = 2'd1,
        CPLD = 2'd2
    } cpl_type_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned BEAT_DW = 32;

    // A length of 0 DW encodes the maximum (2**len_width DW).
    function automatic int unsigned cpl_beats(input int unsigned len,
                                              input int unsigned len_width,
                                              input int unsigned beat_dw);
        int unsigned dw;
        dw = (len == 0) ? (32'd1 << len_width) : len;
        return (dw + beat_dw - 1) / beat_dw;
    endfunction

endpackage

// File: rtl/cpl_source_arbiter_counter.sv
// Loadable down-counter holding the R beats still owed by the locked source.
module cpl_beat_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cpl_source_arbiter.sv
// Round-robin arbiter sharing the completion push port between the P2A path
// (src0) and the local error source (src1); grant is locked for CPLD bursts.
module cpl_source_arbiter #(
    parameter int unsigned DATA_WIDTH = 1034,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned BEAT_DW    = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [1:0]            src0_type,
    input  logic [LEN_WIDTH-1:0]  src0_length,
    input  logic [DATA_WIDTH-1:0] src0_data,
    output logic                  src0_grant,
    output logic                  src0_command,
    input  logic [1:0]            src1_type,
    input  logic [LEN_WIDTH-1:0]  src1_length,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src1_grant,
    output logic                  src1_command,
    output logic [1:0]            fsm_type,
    output logic [LEN_WIDTH-1:0]  fsm_length,
    output logic [DATA_WIDTH-1:0] fsm_data,
    input  logic                  fsm_grant,
    input  logic                  fsm_command
);

    import axi_slave_package::NONE;
    import axi_slave_package::CPLD;
    import axi_slave_package::arb_state_t;
    import axi_slave_package::ARB_IDLE;
    import axi_slave_package::ARB_LOCK;
    import axi_slave_package::cpl_beats;

    localparam int unsigned MAX_BEATS = (32'd1 << LEN_WIDTH) / BEAT_DW;
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

    arb_state_t state_q, state_d;
    logic       rr_q, rr_d;
    logic       sel_q, sel_d;

    logic                  req0, req1, any_req, chosen, active;
    logic                  idle_grant, lock_beat;
    logic [1:0]            mux_type;
    logic [LEN_WIDTH-1:0]  mux_len;
    logic [DATA_WIDTH-1:0] mux_data;
    logic [CNT_W-1:0]      beats, remaining;
    logic                  cnt_zero, cnt_load;

    always_comb begin
        req0    = (src0_type != NONE);
        req1    = (src1_type != NONE);
        any_req = req0 | req1;

        if (state_q == ARB_LOCK) begin
            chosen = sel_q;
            active = 1'b1;
        end else begin
            chosen = (req0 && req1) ? rr_q : req1;
            active = any_req;
        end

        mux_type = chosen ? src1_type   : src0_type;
        mux_len  = chosen ? src1_length : src0_length;
        mux_data = chosen ? src1_data   : src0_data;
        beats    = CNT_W'(cpl_beats(32'(mux_len), LEN_WIDTH, BEAT_DW));

        idle_grant = (state_q == ARB_IDLE) && any_req && fsm_grant;
        cnt_load   = idle_grant && (mux_type == CPLD) && (beats > CNT_W'(1));
        lock_beat  = (state_q == ARB_LOCK) && fsm_command && !fsm_grant;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        case (state_q)
            ARB_IDLE: begin
                if (idle_grant) begin
                    rr_d = ~chosen;
                end
                if (cnt_load) begin
                    sel_d   = chosen;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // Unlock as the last beat is consumed so the next cycle is arbitrated.
                if ((lock_beat && (remaining == CNT_W'(1))) || cnt_zero) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ARB_IDLE;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
        end
    end

    cpl_beat_counter #(
        .WIDTH(CNT_W)
    ) u_beat_counter (
        .clk_i      (clk),
        .arst_i     (arst),
        .load_i     (cnt_load),
        .load_val_i (beats - CNT_W'(1)),
        .en_i       (lock_beat),
        .count_o    (remaining),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        fsm_type     = NONE;
        fsm_length   = '0;
        fsm_data     = '0;
        src0_grant   = 1'b0;
        src1_grant   = 1'b0;
        src0_command = 1'b0;
        src1_command = 1'b0;
        if (!arst && active) begin
            fsm_type     = mux_type;
            fsm_length   = mux_len;
            fsm_data     = mux_data;
            src0_grant   = idle_grant && !chosen;
            src1_grant   = idle_grant && chosen;
            src0_command = fsm_command && !chosen;
            src1_command = fsm_command && chosen;
        end
    end

endmodule
